dut_lane_test_ctrl: RTL and testbench
=====================================

Name: dut_lane_test_ctrl

Overview:
- Run controller for a bank of N_LANES FSM test lanes (pattern generator -> FSM chain -> checker).
- Sequences each test run: lane reset, settle window, timed run with periodic round-robin error injection, then result hold.
- Aggregates per-lane `err_data`/`err_state` flags into sticky flags and saturating counters for readout by the test system.

Parameters:
- N_LANES, 4, number of lanes controlled.
- RST_CYCLES, 16, cycles `lane_rst_o` is held high in RESET (>=1).
- SETTLE_CYCLES, 64, cycles after lane reset release during which checker errors are ignored; must be >= chain latency (>=1).
- INJ_PERIOD, 1024, RUN cycles between injection pulses (>=2).
- ERR_CNT_W, 16, width of error and injection counters.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-low reset
- start_i  in  1  start run; level-sampled in IDLE/DONE
- stop_i  in  1  abort/end run
- inj_en_i  in  1  enable periodic injection during RUN
- run_len_i  in  32  RUN length in cycles, captured on start; 0 = run until stop_i
- err_data_i  in  N_LANES  per-lane checker data error
- err_state_i  in  N_LANES  per-lane checker state error
- lane_rst_o  out  1  active-high reset to all lanes
- lane_inj_err_o  out  N_LANES  one-hot single-cycle injection pulse
- err_sticky_o  out  N_LANES  per-lane sticky error (data OR state)
- err_cnt_o  out  ERR_CNT_W  RUN cycles with any lane error, saturating
- inj_cnt_o  out  ERR_CNT_W  injections issued, saturating
- busy_o  out  1  high in RESET/SETTLE/RUN
- done_o  out  1  high in DONE

Behaviour:
- All outputs registered.
- Reset (`rst_i`=0 at clock edge): state IDLE, `lane_rst_o`=1, all other outputs 0, injection lane pointer=0, timers=0.
- States and transitions:
  - IDLE: `lane_rst_o`=1. If `start_i` & !`stop_i` -> RESET. On this transition: clear `err_sticky_o`/`err_cnt_o`/`inj_cnt_o`, pointer=0, capture `run_len_i`.
  - RESET: `lane_rst_o`=1 for exactly RST_CYCLES cycles, then -> SETTLE.
  - SETTLE: `lane_rst_o`=0, error inputs ignored, exactly SETTLE_CYCLES cycles, then -> RUN.
  - RUN: `lane_rst_o`=0; errors and injection active. Exit -> DONE on `stop_i`, or after exactly run_len cycles when run_len != 0.
  - DONE: `done_o`=1, `lane_rst_o`=1, results frozen. `start_i` & !`stop_i` -> RESET with the same clearing as from IDLE. Otherwise stays in DONE.
- `stop_i` in RESET/SETTLE -> DONE next cycle. `stop_i` has priority over `start_i` in every state.
- `start_i` ignored while busy.
- `busy_o`/`done_o` reflect the state they are registered alongside (same cycle as state).
- Injection:
  - Timer counts RUN cycles only; resets to 0 on RUN entry and on each pulse.
  - When timer = INJ_PERIOD-1 and `inj_en_i`=1: `lane_inj_err_o[pointer]`=1 for one cycle, `inj_cnt_o`++ (saturating), pointer advances modulo N_LANES.
  - If `inj_en_i`=0, the timer still wraps but no pulse is issued and the pointer holds.
  - No pulse outside RUN. A pulse coincident with the RUN exit cycle is suppressed.
- Error capture (RUN only, errors sampled each cycle):
  - `err_sticky_o[i]` |= `err_data_i[i]` | `err_state_i[i]`.
  - `err_cnt_o` += 1 if any lane bit is set; saturates at all-ones.
  - Errors in the RUN-exit cycle are still counted.
- Mid-operation `rst_i` low: immediate return to reset values on that edge; `lane_rst_o`=1.
- RTL size target: ~200 lines.

Optional Feature:
- Macro: DUT_LANE_TEST_CTRL_PER_LANE_CNT_EN.
- Defined: adds output `lane_err_cnt_o` (N_LANES*ERR_CNT_W). Lane i occupies bits [i*ERR_CNT_W +: ERR_CNT_W] and counts RUN cycles with that lane's error set; saturating; cleared with the other counters.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
(N_LANES=4, RST_CYCLES=16, SETTLE_CYCLES=64, INJ_PERIOD=100)
- Reset then idle -> `lane_rst_o`=1, `busy_o`=0, `done_o`=0, all counters 0.
- start, run_len=1000, `inj_en_i`=0, no errors -> `lane_rst_o` high 16 cycles after start, low 64+1000 cycles, then `done_o`=1; `err_cnt_o`=0, `inj_cnt_o`=0.
- start, run_len=1000, `inj_en_i`=1 -> 10 pulses at RUN cycles 99, 199, ... 999 on lanes 0,1,2,3,0,...; `inj_cnt_o`=10; with lanes in loop, `err_sticky_o`=4'b1111 and `err_cnt_o`>=10.
- run_len=0, `err_state_i[2]` forced high 5 cycles in RUN, `stop_i` at RUN cycle 300 -> DONE next cycle; `err_sticky_o`=4'b0100, `err_cnt_o`=5.
- Errors driven during SETTLE, `stop_i` during RESET -> errors ignored; DONE entered next cycle after stop; `start_i`+`stop_i` together in DONE -> remains DONE.
- ERR_CNT_W=4, error held 40 RUN cycles -> `err_cnt_o` saturates at 15; `rst_i` low mid-RUN -> all outputs to reset values next edge.

Source files
------------

// File: rtl/dut_lane_test_ctrl.sv
// dut_lane_test_ctrl: run controller for a bank of FSM test lanes.
// Each run holds the lanes in reset, waits out a settle window, runs for a
// programmed length while injecting round-robin single-cycle errors, then
// freezes the collected results in DONE until the next start.
// Optional build macro DUT_LANE_TEST_CTRL_PER_LANE_CNT_EN adds one saturating
// error counter per lane on lane_err_cnt_o.
module dut_lane_test_ctrl #(
  parameter int N_LANES       = 4,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int INJ_PERIOD    = 1024,
  parameter int ERR_CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 inj_en_i,
  input  logic [31:0]          run_len_i,
  input  logic [N_LANES-1:0]   err_data_i,
  input  logic [N_LANES-1:0]   err_state_i,
  output logic                 lane_rst_o,
  output logic [N_LANES-1:0]   lane_inj_err_o,
  output logic [N_LANES-1:0]   err_sticky_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [ERR_CNT_W-1:0] inj_cnt_o,
  output logic                 busy_o,
  output logic                 done_o
`ifdef DUT_LANE_TEST_CTRL_PER_LANE_CNT_EN
  ,
  output logic [N_LANES*ERR_CNT_W-1:0] lane_err_cnt_o
`endif
);

  localparam int PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int INJ_W = $clog2(INJ_PERIOD);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [31:0]          RST_LAST    = 32'(RST_CYCLES - 1);
  localparam logic [31:0]          SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [INJ_W-1:0]     INJ_LAST    = INJ_W'(INJ_PERIOD - 1);
  localparam logic [PTR_W-1:0]     PTR_LAST    = PTR_W'(N_LANES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_SETTLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [31:0]        stateTimer_q;
  logic [31:0]        runLen_q;
  logic [INJ_W-1:0]   injTimer_q;
  logic [INJ_W-1:0]   injTimer_d;
  logic [PTR_W-1:0]   injPtr_q;
  logic [N_LANES-1:0] laneErr;
  logic               startReq;
  logic               runLast;
  logic               runStart;
  logic               injFire;

  // Next-state decode plus the injection decision; a pulse is only issued when
  // the controller stays in RUN, so a pulse can never appear outside RUN.
  always_comb begin
    laneErr    = err_data_i | err_state_i;
    startReq   = start_i & ~stop_i;
    runLast    = (runLen_q != 32'd0) && (stateTimer_q == runLen_q - 32'd1);
    injTimer_d = (injTimer_q == INJ_LAST) ? '0 : injTimer_q + 1'b1;
    state_d    = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (startReq) state_d = ST_RESET;
      end
      ST_RESET: begin
        if (stop_i)                         state_d = ST_DONE;
        else if (stateTimer_q == RST_LAST)  state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (stop_i)                           state_d = ST_DONE;
        else if (stateTimer_q == SETTLE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop_i || runLast) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (startReq) state_d = ST_RESET;
      end
      default: state_d = ST_IDLE;
    endcase
    runStart = (state_d == ST_RESET) && (state_q != ST_RESET);
    injFire  = (state_q == ST_RUN) && (state_d == ST_RUN) && inj_en_i &&
               (injTimer_d == INJ_LAST);
  end

  // Controller state, timers, result registers and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q        <= ST_IDLE;
      stateTimer_q   <= '0;
      runLen_q       <= '0;
      injTimer_q     <= '0;
      injPtr_q       <= '0;
      lane_rst_o     <= 1'b1;
      lane_inj_err_o <= '0;
      err_sticky_o   <= '0;
      err_cnt_o      <= '0;
      inj_cnt_o      <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_o         <= (state_d == ST_RESET) || (state_d == ST_SETTLE) ||
                        (state_d == ST_RUN);
      done_o         <= (state_d == ST_DONE);
      lane_rst_o     <= !((state_d == ST_SETTLE) || (state_d == ST_RUN));
      lane_inj_err_o <= '0;

      if (state_d != state_q) begin
        stateTimer_q <= '0;
      end else if (busy_o) begin
        stateTimer_q <= stateTimer_q + 32'd1;
      end

      if (runStart) begin
        err_sticky_o <= '0;
        err_cnt_o    <= '0;
        inj_cnt_o    <= '0;
        injPtr_q     <= '0;
        runLen_q     <= run_len_i;
      end

      if (state_q == ST_RUN) begin
        err_sticky_o <= err_sticky_o | laneErr;
        if ((|laneErr) && (err_cnt_o != CNT_MAX)) begin
          err_cnt_o <= err_cnt_o + 1'b1;
        end
        injTimer_q <= injTimer_d;
      end else begin
        injTimer_q <= '0;
      end

      if (injFire) begin
        for (int i = 0; i < N_LANES; i++) begin
          lane_inj_err_o[i] <= (injPtr_q == PTR_W'(i));
        end
        if (inj_cnt_o != CNT_MAX) begin
          inj_cnt_o <= inj_cnt_o + 1'b1;
        end
        injPtr_q <= (injPtr_q == PTR_LAST) ? '0 : injPtr_q + 1'b1;
      end
    end
  end

`ifdef DUT_LANE_TEST_CTRL_PER_LANE_CNT_EN
  // Per-lane saturating count of RUN cycles with that lane's error set.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lane_err_cnt_o <= '0;
    end else if (runStart) begin
      lane_err_cnt_o <= '0;
    end else if (state_q == ST_RUN) begin
      for (int i = 0; i < N_LANES; i++) begin
        if (laneErr[i] && (lane_err_cnt_o[i*ERR_CNT_W +: ERR_CNT_W] != CNT_MAX)) begin
          lane_err_cnt_o[i*ERR_CNT_W +: ERR_CNT_W] <=
            lane_err_cnt_o[i*ERR_CNT_W +: ERR_CNT_W] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dut_lane_test_ctrl.sv
// tb_dut_lane_test_ctrl: randomized bench for dut_lane_test_ctrl.
// The reference model derives the expected phase of a run from the number of
// clock edges since start (reset window, settle window, run length, stop
// edge), expects injection pulses at every INJ_PERIOD-th run cycle on lanes in
// round-robin order, and accumulates error flags/counts for the run phase.
module tb_dut_lane_test_ctrl;

  localparam int N_LANES       = 4;
  localparam int RST_CYCLES    = 16;
  localparam int SETTLE_CYCLES = 64;
  localparam int INJ_PERIOD    = 100;
  localparam int ERR_CNT_W     = 4;
  localparam int CNT_MAX       = (1 << ERR_CNT_W) - 1;
  localparam int PRE_RUN       = RST_CYCLES + SETTLE_CYCLES;

  localparam int PH_IDLE   = 0;
  localparam int PH_RESET  = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_DONE   = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 start_i;
  logic                 stop_i;
  logic                 inj_en_i;
  logic [31:0]          run_len_i;
  logic [N_LANES-1:0]   err_data_i;
  logic [N_LANES-1:0]   err_state_i;
  logic                 lane_rst_o;
  logic [N_LANES-1:0]   lane_inj_err_o;
  logic [N_LANES-1:0]   err_sticky_o;
  logic [ERR_CNT_W-1:0] err_cnt_o;
  logic [ERR_CNT_W-1:0] inj_cnt_o;
  logic                 busy_o;
  logic                 done_o;
`ifdef DUT_LANE_TEST_CTRL_PER_LANE_CNT_EN
  logic [N_LANES*ERR_CNT_W-1:0] lane_err_cnt_o;
`endif

  int vecCount  = 0;
  int missCount = 0;

  logic [N_LANES-1:0] expSticky;
  logic [N_LANES-1:0] expPulse;
  int                 expErrCnt;
  int                 expInjCnt;

  dut_lane_test_ctrl #(
    .N_LANES       (N_LANES),
    .RST_CYCLES    (RST_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .INJ_PERIOD    (INJ_PERIOD),
    .ERR_CNT_W     (ERR_CNT_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .inj_en_i       (inj_en_i),
    .run_len_i      (run_len_i),
    .err_data_i     (err_data_i),
    .err_state_i    (err_state_i),
    .lane_rst_o     (lane_rst_o),
    .lane_inj_err_o (lane_inj_err_o),
    .err_sticky_o   (err_sticky_o),
    .err_cnt_o      (err_cnt_o),
    .inj_cnt_o      (inj_cnt_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
`ifdef DUT_LANE_TEST_CTRL_PER_LANE_CNT_EN
    ,
    .lane_err_cnt_o (lane_err_cnt_o)
`endif
  );

  // Free-running system clock.
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s @%0t: observed 0x%0h, expected 0x%0h",
               tag, $time, observed, expected);
    end
  endtask

  // Phase the controller should be in after edge a of a run (edge 1 samples start).
  function automatic int phaseOf(input int a, input int runLen, input int stopAt);
    if (stopAt > 0 && a >= stopAt) return PH_DONE;
    if (a <= RST_CYCLES) return PH_RESET;
    if (a <= PRE_RUN) return PH_SETTLE;
    if (runLen == 0 || a <= PRE_RUN + runLen) return PH_RUN;
    return PH_DONE;
  endfunction

  task automatic checkAll(input int ph);
    checkOutput("lane_rst", 32'(lane_rst_o), 32'((ph != PH_SETTLE) && (ph != PH_RUN)));
    checkOutput("busy", 32'(busy_o),
                32'((ph == PH_RESET) || (ph == PH_SETTLE) || (ph == PH_RUN)));
    checkOutput("done", 32'(done_o), 32'(ph == PH_DONE));
    checkOutput("inj_pulse", 32'(lane_inj_err_o), 32'(expPulse));
    checkOutput("err_sticky", 32'(err_sticky_o), 32'(expSticky));
    checkOutput("err_cnt", 32'(err_cnt_o), 32'(expErrCnt));
    checkOutput("inj_cnt", 32'(inj_cnt_o), 32'(expInjCnt));
  endtask

  task automatic randomErrors(input int pct);
    for (int i = 0; i < N_LANES; i++) begin
      err_data_i[i]  = ($urandom_range(0, 99) < pct);
      err_state_i[i] = ($urandom_range(0, 99) < pct);
    end
  endtask

  task automatic applyReset(input int cycles);
    rst_i     = 1'b0;
    start_i   = 1'b1;
    stop_i    = 1'b0;
    run_len_i = $urandom;
    randomErrors(30);
    expSticky = '0;
    expPulse  = '0;
    expErrCnt = 0;
    expInjCnt = 0;
    repeat (cycles) begin
      @(posedge clk_i);
      @(negedge clk_i);
      checkAll(PH_IDLE);
    end
    rst_i   = 1'b1;
    start_i = 1'b0;
  endtask

  // Idle with start only ever raised together with stop: must stay IDLE.
  task automatic idleCycles(input int cycles);
    repeat (cycles) begin
      start_i = 1'($urandom_range(0, 1));
      stop_i  = start_i | 1'($urandom_range(0, 1));
      randomErrors(30);
      @(posedge clk_i);
      @(negedge clk_i);
      checkAll(PH_IDLE);
    end
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  // One complete run: start on edge 1, optional stop on edge stopAt, then
  // linger in DONE until totalEdges; injected pulses are looped back as errors.
  task automatic applyStimulus(input int runLen, input bit injEn, input int errPctRun,
                               input int errPctIdle, input bit lane2Burst,
                               input int stopAt, input int totalEdges,
                               input bit doneStartStop);
    int prevPh;
    int ph;
    int r;
    int prevR;
    logic [N_LANES-1:0] eData;
    logic [N_LANES-1:0] eState;
    $display("[TB] run len=%0d inj=%0d stopAt=%0d", runLen, injEn, stopAt);
    inj_en_i = injEn;
    expPulse = '0;
    for (int a = 1; a <= totalEdges; a++) begin
      prevPh = (a == 1) ? PH_IDLE : phaseOf(a - 1, runLen, stopAt);
      prevR  = a - 1 - PRE_RUN - 1;
      if (a == 1) begin
        start_i   = 1'b1;
        stop_i    = 1'b0;
        run_len_i = 32'(runLen);
      end else begin
        run_len_i = $urandom;
        if (prevPh == PH_DONE) begin
          start_i = doneStartStop ? 1'($urandom_range(0, 1)) : 1'b0;
          stop_i  = start_i | 1'($urandom_range(0, 1));
        end else begin
          start_i = 1'($urandom_range(0, 1));
          stop_i  = (a == stopAt);
        end
      end
      randomErrors((prevPh == PH_RUN) ? errPctRun : errPctIdle);
      eData  = err_data_i;
      eState = err_state_i;
      if (injEn) eData = eData | expPulse;
      if (lane2Burst && prevPh == PH_RUN && prevR >= 50 && prevR < 55) eState[2] = 1'b1;
      err_data_i  = eData;
      err_state_i = eState;
      if (a == 1) begin
        expSticky = '0;
        expErrCnt = 0;
        expInjCnt = 0;
      end else if (prevPh == PH_RUN) begin
        expSticky = expSticky | eData | eState;
        if (((eData | eState) != '0) && expErrCnt < CNT_MAX) expErrCnt++;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      ph       = phaseOf(a, runLen, stopAt);
      r        = a - PRE_RUN - 1;
      expPulse = '0;
      if (ph == PH_RUN && injEn && (r % INJ_PERIOD) == INJ_PERIOD - 1) begin
        expPulse[(r / INJ_PERIOD) % N_LANES] = 1'b1;
        if (expInjCnt < CNT_MAX) expInjCnt++;
      end
      checkAll(ph);
    end
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  initial begin
    int len;
    int stopAt;
    rst_i       = 1'b0;
    start_i     = 1'b0;
    stop_i      = 1'b0;
    inj_en_i    = 1'b0;
    run_len_i   = '0;
    err_data_i  = '0;
    err_state_i = '0;

    applyReset(2);
    idleCycles(6);

    // Plain timed run, then the same with injection looped back as errors.
    applyStimulus(1000, 1'b0, 0, 0, 1'b0, 0, PRE_RUN + 1000 + 8, 1'b0);
    applyStimulus(1000, 1'b1, 0, 0, 1'b0, 0, PRE_RUN + 1000 + 8, 1'b1);

    // Open-ended run, five-cycle lane 2 state error, stop in run cycle 300.
    applyStimulus(0, 1'b0, 0, 30, 1'b1, PRE_RUN + 302, PRE_RUN + 310, 1'b1);

    // Stop during RESET and during SETTLE, with errors that must be ignored.
    applyStimulus(200, 1'b1, 2, 30, 1'b0, 5, 12, 1'b1);
    applyStimulus(300, 1'b1, 2, 30, 1'b0, RST_CYCLES + 10, RST_CYCLES + 20, 1'b0);

    // Dense errors drive the error counter into saturation.
    applyStimulus(100, 1'b0, 50, 0, 1'b0, 0, PRE_RUN + 106, 1'b0);

    // Open-ended run cut short by reset in the middle of RUN.
    applyStimulus(0, 1'b1, 3, 5, 1'b0, 0, PRE_RUN + 150, 1'b0);
    applyReset(2);
    idleCycles(3);

    for (int k = 0; k < 4; k++) begin
      len    = $urandom_range(120, 400);
      stopAt = ($urandom_range(0, 1) == 1) ? $urandom_range(2, PRE_RUN + len) : 0;
      applyStimulus(len, 1'($urandom_range(0, 1)), 2, 10, 1'b0, stopAt,
                    PRE_RUN + len + 8, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
